// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: op/dev codes, tag field positions and responder states.
// The guarded macros keep one definition of the op/dev codes for every file that compiles after this one.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b0
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

package sysbus_pkg;

  localparam int OP_BIT     = 12;
  localparam int DEV_MSB    = 11;
  localparam int DEV_LSB    = 8;
  localparam int LINE_BEATS = 8;

  localparam logic       OP_READ    = `SYSBUS_READ;
  localparam logic       OP_WRITE   = `SYSBUS_WRITE;
  localparam logic [3:0] DEV_MEMORY = `SYSBUS_MEMORY;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_LAT  = 2'd1,
    RD_RESP = 2'd2,
    WR_DATA = 2'd3
  } resp_state_t;

  // Builds a request tag from its op and device fields; the low byte is always zero.
  function automatic logic [12:0] make_tag(input logic op, input logic [3:0] dev);
    return {op, dev, 8'h00};
  endfunction

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus line-protocol signal bundle; the initiator uses master, the memory uses slave.
interface sysbus_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
);
  logic              reqcyc;
  logic [DATA_W-1:0] req;
  logic [TAG_W-1:0]  reqtag;
  logic              respack;
  logic              reqack;
  logic              respcyc;
  logic [DATA_W-1:0] resp;
  logic [TAG_W-1:0]  resptag;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/sysbus_mem_array.sv
// Word storage behind the responder: one synchronous write port, one combinational read port.
module sysbus_mem_array #(
  parameter int MEM_WORDS = 1024,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents start at zero and are deliberately untouched by reset.
  logic [DATA_W-1:0] mem_r [MEM_WORDS] = '{default: '0};

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: serves 8-beat line reads and writes from a word-addressed array.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 1024,
  parameter int READ_LATENCY   = 4
) (
  input  logic     clk,
  input  logic     reset,
  sysbus_if.slave  bus
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] LAT_INIT  = CW'(READ_LATENCY - 1);
  localparam logic [AW-1:0] LINE_MASK = AW'(LINE_BEATS - 1);

  resp_state_t              state_r;
  logic [AW-1:0]            base_r;
  logic [2:0]               beat_r;
  logic [CW-1:0]            cnt_r;
  logic [BUS_TAG_WIDTH-1:0] tag_r;
  logic                     is_mem_r;

  logic [AW-1:0]             hdr_base_s;
  logic [AW-1:0]             addr_s;
  logic [BUS_DATA_WIDTH-1:0] rdata_s;
  logic                      wr_en_s;

  // Byte offset bits are dropped and the word index is forced to a line boundary.
  assign hdr_base_s = bus.req[3 +: AW] & ~LINE_MASK;
  assign addr_s     = base_r | AW'(beat_r);

  sysbus_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .DATA_W    (BUS_DATA_WIDTH),
    .ADDR_W    (AW)
  ) u_array (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (addr_s),
    .wdata (bus.req),
    .raddr (addr_s),
    .rdata (rdata_s)
  );

  // Bus outputs and write enable; reqack must answer in the same cycle as reqcyc.
  always_comb begin
    bus.reqack  = 1'b0;
    bus.respcyc = 1'b0;
    bus.resp    = '0;
    bus.resptag = '0;
    wr_en_s     = 1'b0;
    if (reset) begin
      bus.reqack  = 1'b0;
      bus.respcyc = 1'b0;
    end else begin
      case (state_r)
        IDLE:    bus.reqack = bus.reqcyc;
        RD_LAT:  bus.reqack = 1'b0;
        RD_RESP: begin
          bus.respcyc = 1'b1;
          bus.resp    = is_mem_r ? rdata_s : '0;
          bus.resptag = tag_r;
        end
        WR_DATA: begin
          bus.reqack = bus.reqcyc;
          wr_en_s    = bus.reqcyc & is_mem_r;
        end
        default: bus.reqack = 1'b0;
      endcase
    end
  end

  // Transaction FSM: header capture, read latency, read beats and write beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      beat_r   <= 3'd0;
      cnt_r    <= '0;
      tag_r    <= '0;
      base_r   <= '0;
      is_mem_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.reqcyc) begin
            tag_r    <= bus.reqtag;
            base_r   <= hdr_base_s;
            is_mem_r <= (bus.reqtag[DEV_MSB:DEV_LSB] == DEV_MEMORY);
            beat_r   <= 3'd0;
            if (bus.reqtag[OP_BIT] == OP_READ) begin
              // A latency of one means the first beat follows the header directly.
              if (READ_LATENCY > 1) begin
                state_r <= RD_LAT;
                cnt_r   <= LAT_INIT;
              end else begin
                state_r <= RD_RESP;
                cnt_r   <= '0;
              end
            end else begin
              state_r <= WR_DATA;
            end
          end
        end
        RD_LAT: begin
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r <= CW'(1)) begin
            state_r <= RD_RESP;
            beat_r  <= 3'd0;
          end
        end
        RD_RESP: begin
          if (bus.respack) begin
            beat_r <= beat_r + 3'd1;
            if (beat_r == 3'd7) begin
              state_r <= IDLE;
            end
          end
        end
        WR_DATA: begin
          if (bus.reqcyc) begin
            beat_r <= beat_r + 3'd1;
            if (beat_r == 3'd7) begin
              state_r <= IDLE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder: table-driven line transactions,
// hand-written corner sequences and randomized traffic against a line-level memory model.
module tb_sysbus_mem_responder;
  import sysbus_pkg::*;

  localparam int MEM_WORDS    = 1024;
  localparam int READ_LATENCY = 4;
  localparam logic [3:0] DEV_OTHER = 4'b0011;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [3:0]  dev;
    logic [63:0] val;   // write: first data word; read: expected first word (0 = whole line zero)
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [63:0] model_mem [MEM_WORDS];
  logic [63:0] rd_buf [LINE_BEATS];
  vec_t        vecs [9];

  sysbus_if #(.DATA_W(64), .TAG_W(13)) bus ();

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .MEM_WORDS      (MEM_WORDS),
    .READ_LATENCY   (READ_LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Model address map: 64-byte lines, line index wraps modulo the number of lines.
  function automatic int word_of(input logic [63:0] addr, input int i);
    return int'((addr / 64'd64) % 64'(MEM_WORDS / LINE_BEATS)) * LINE_BEATS + i;
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] addr, input logic [3:0] dev, input int i);
    return (dev == DEV_MEMORY) ? model_mem[word_of(addr, i)] : 64'd0;
  endfunction

  task automatic do_write(input logic [63:0] addr, input logic [3:0] dev,
                          input logic [63:0] seed, input bit rand_gap);
    int g;
    bus.reqcyc = 1'b1;
    bus.req    = addr;
    bus.reqtag = make_tag(OP_WRITE, dev);
    #3;
    check("wr_hdr_ack", bus.reqack, 1'b1);
    next();
    for (int b = 0; b < LINE_BEATS; b++) begin
      g = rand_gap ? $urandom_range(0, 2) : 0;
      repeat (g) begin
        bus.reqcyc = 1'b0;
        bus.req    = {$urandom, $urandom};
        #3;
        check("wr_gap_ack", bus.reqack, 1'b0);
        next();
      end
      bus.reqcyc = 1'b1;
      bus.req    = seed - 64'(b);
      bus.reqtag = 13'($urandom);
      #3;
      check("wr_beat_ack", bus.reqack, 1'b1);
      next();
      if (dev == DEV_MEMORY) model_mem[word_of(addr, b)] = seed - 64'(b);
    end
    bus.reqcyc = 1'b0;
  endtask

  // Issues a read header and collects the 8 beats into rd_buf, checking latency,
  // tag, hold-under-backpressure and (optionally) that a pending header is refused.
  task automatic do_read(input logic [63:0] addr, input logic [3:0] dev,
                         input int stall_beat, input int stall_len,
                         input bit rand_stall, input bit hdr_during);
    logic [12:0] tag;
    logic [63:0] held;
    int lat;
    int k;
    tag = make_tag(OP_READ, dev);
    bus.reqcyc  = 1'b1;
    bus.req     = addr;
    bus.reqtag  = tag;
    bus.respack = 1'b0;
    #3;
    check("rd_hdr_ack", bus.reqack, 1'b1);
    next();
    if (hdr_during) begin
      bus.req    = 64'h0000_0000_0000_1000;
      bus.reqtag = make_tag(OP_READ, DEV_MEMORY);
    end else begin
      bus.reqcyc = 1'b0;
    end
    lat = 1;
    #3;
    while (bus.respcyc !== 1'b1 && lat < 64) begin
      if (hdr_during) check("rd_lat_pending_ack", bus.reqack, 1'b0);
      next();
      lat++;
      #3;
    end
    check("rd_latency", 64'(lat), 64'(READ_LATENCY));
    for (int b = 0; b < LINE_BEATS; b++) begin
      k = (b == stall_beat) ? stall_len : (rand_stall ? $urandom_range(0, 2) : 0);
      held = bus.resp;
      for (int s = 0; s <= k; s++) begin
        check("rd_respcyc", bus.respcyc, 1'b1);
        check("rd_resptag", 64'(bus.resptag), 64'(tag));
        if (s > 0) check("rd_hold", bus.resp, held);
        if (hdr_during) check("rd_resp_pending_ack", bus.reqack, 1'b0);
        bus.respack = (s == k);
        next();
        #3;
      end
      rd_buf[b] = held;
    end
    bus.respack = 1'b0;
    bus.reqcyc  = 1'b0;
    check("rd_done_respcyc", bus.respcyc, 1'b0);
    next();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] addr;
    logic [3:0]  dev;

    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = 64'd0;

    vecs[0] = '{1'b1, 64'h0000_0000_0000_1000, DEV_MEMORY, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1] = '{1'b0, 64'h0000_0000_0000_1000, DEV_MEMORY, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{1'b0, 64'h0000_0000_0000_1028, DEV_MEMORY, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{1'b1, 64'h0000_0000_0000_1000, DEV_OTHER,  64'h1234_5678_0000_0010};
    vecs[4] = '{1'b0, 64'h0000_0000_0000_1000, DEV_MEMORY, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{1'b0, 64'h0000_0000_0000_1000, DEV_OTHER,  64'h0000_0000_0000_0000};
    vecs[6] = '{1'b1, 64'h0000_0000_0001_2040, DEV_MEMORY, 64'hA5A5_0000_0000_0020};
    vecs[7] = '{1'b0, 64'h0000_0000_0000_0040, DEV_MEMORY, 64'hA5A5_0000_0000_0020};
    vecs[8] = '{1'b0, 64'h0000_0000_0000_0000, DEV_MEMORY, 64'h0000_0000_0000_0000};

    bus.reqcyc  = 1'b1;
    bus.req     = 64'h0000_0000_0000_1000;
    bus.reqtag  = make_tag(OP_READ, DEV_MEMORY);
    bus.respack = 1'b0;
    reset       = 1'b1;
    next();
    next();
    #3;
    check("reset_reqack", bus.reqack, 1'b0);
    check("reset_respcyc", bus.respcyc, 1'b0);
    check("reset_resp", bus.resp, 64'd0);
    check("reset_resptag", 64'(bus.resptag), 64'd0);
    bus.reqcyc = 1'b0;
    reset      = 1'b0;
    next();

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].wr) begin
        do_write(vecs[v].addr, vecs[v].dev, vecs[v].val, 1'b0);
      end else begin
        do_read(vecs[v].addr, vecs[v].dev, -1, 0, 1'b0, 1'b0);
        for (int b = 0; b < LINE_BEATS; b++)
          check($sformatf("vec%0d_beat%0d", v, b), rd_buf[b],
                (vecs[v].val == 64'd0) ? 64'd0 : vecs[v].val - 64'(b));
      end
    end

    // Backpressure on beat 2, then a header left pending through the whole read.
    do_read(64'h0000_0000_0000_1000, DEV_MEMORY, 2, 3, 1'b0, 1'b0);
    check("bp_beat2", rd_buf[2], 64'hFFFF_FFFF_FFFF_FFFD);
    check("bp_beat7", rd_buf[7], 64'hFFFF_FFFF_FFFF_FFF8);
    do_read(64'h0000_0000_0000_1028, DEV_MEMORY, -1, 0, 1'b0, 1'b1);
    check("pend_beat0", rd_buf[0], 64'hFFFF_FFFF_FFFF_FFFF);

    // One-cycle reset during beat 4 aborts the read.
    bus.reqcyc  = 1'b1;
    bus.req     = 64'h0000_0000_0000_1000;
    bus.reqtag  = make_tag(OP_READ, DEV_MEMORY);
    #3;
    check("rst_hdr_ack", bus.reqack, 1'b1);
    next();
    bus.reqcyc = 1'b0;
    repeat (READ_LATENCY - 1) next();
    for (int b = 0; b < 4; b++) begin
      bus.respack = 1'b1;
      #3;
      check("rst_seq_beat", bus.resp, 64'hFFFF_FFFF_FFFF_FFFF - 64'(b));
      next();
    end
    bus.respack = 1'b0;
    #3;
    check("rst_beat4_valid", bus.respcyc, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_during_respcyc", bus.respcyc, 1'b0);
    check("rst_during_resp", bus.resp, 64'd0);
    next();
    reset = 1'b0;
    #3;
    check("rst_after_respcyc", bus.respcyc, 1'b0);
    next();
    do_read(64'h0000_0000_0000_1000, DEV_MEMORY, -1, 0, 1'b0, 1'b0);
    for (int b = 0; b < LINE_BEATS; b++)
      check("rst_reread", rd_buf[b], 64'hFFFF_FFFF_FFFF_FFFF - 64'(b));

    // Randomized traffic over a few aliased lines, with gaps and stalls.
    for (int t = 0; t < 60; t++) begin
      addr = (64'($urandom_range(0, 7)) << 6) | 64'($urandom_range(0, 63)) | (64'($urandom) << 16);
      dev  = ($urandom_range(0, 4) == 0) ? DEV_OTHER : DEV_MEMORY;
      if ($urandom_range(0, 1) == 1) begin
        do_write(addr, dev, {$urandom, $urandom}, 1'b1);
      end else begin
        do_read(addr, dev, -1, 0, 1'b1, 1'b0);
        for (int b = 0; b < LINE_BEATS; b++)
          check($sformatf("rand%0d_beat%0d", t, b), rd_buf[b], model_read(addr, dev, b));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
- Memory-side responder for the Sysbus line protocol. It serves 8-beat (64-byte) line reads and line writes issued by the core's fetch/write FSM.
- Used as the memory model behind the core in simulation and in block-level benches, and as the downstream endpoint for a future cache.
- Owns a word-addressed 64-bit storage array.

Parameters:
- BUS_DATA_WIDTH, 64, data/address bus width.
- BUS_TAG_WIDTH, 13, tag width; tag = {op[12], dev[11:8], 8'b0}.
- MEM_WORDS, 1024, storage depth in 64-bit words; must be a power of 2 and at least 8.
- READ_LATENCY, 4, cycles from the read-header ack to the first response beat; minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- bus_reqcyc  in  1  request valid (header, or write data beat)
- bus_req  in  64  header: byte address; write beat: data word
- bus_reqtag  in  13  request tag; op compared with `SYSBUS_READ/`SYSBUS_WRITE, dev with `SYSBUS_MEMORY
- bus_respack  in  1  initiator accepts the current response beat
- bus_reqack  out  1  request/beat accepted this cycle
- bus_respcyc  out  1  response beat valid
- bus_resp  out  64  response data word
- bus_resptag  out  13  tag of the transaction being answered

Behaviour:
- States: IDLE, RD_LAT, RD_RESP, WR_DATA. Registers: state, line base (word index), beat[2:0], latency counter, captured tag, is_mem flag.
- Reset: every cycle with reset=1 forces state=IDLE, beat=0, counter=0, tag=0. While reset=1: bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0. Storage contents are not cleared; they are zero at time 0.
- Address mapping: word index = bus_req[3 +: log2(MEM_WORDS)] with bits [5:3] forced to 0 (line aligned). Bits [5:0] are ignored. Higher bits wrap modulo MEM_WORDS.
- IDLE:
  - bus_reqack = bus_reqcyc, combinational, same cycle.
  - On reqcyc, capture tag, line base, and is_mem = (dev == `SYSBUS_MEMORY). Then:
  - op READ goes to RD_LAT, counter = READ_LATENCY-1.
  - op WRITE goes to WR_DATA, beat=0.
- RD_LAT: decrement the counter each cycle; at 0 go to RD_RESP with beat=0. If the header ack is in cycle N, the first respcyc is in cycle N+READ_LATENCY.
- RD_RESP:
  - bus_respcyc=1; bus_resp = mem[base+beat] (0 if !is_mem); bus_resptag = captured tag.
  - On bus_respack, beat++. When the acked beat is 7, go to IDLE; respcyc is 0 the next cycle.
  - Without respack, resp, resptag and beat hold stable (backpressure with no limit).
- WR_DATA:
  - bus_reqack = bus_reqcyc, combinational.
  - On reqcyc, write bus_req to mem[base+beat] if is_mem (discarded otherwise) and increment beat. The tag on data beats is ignored.
  - After beat 7 is written, go to IDLE. Gaps (reqcyc=0) are allowed; nothing is written during a gap.
- Outside IDLE and WR_DATA, bus_reqack=0. A new header during RD_LAT or RD_RESP is not acked and stays pending until IDLE.
- Ordering: a write line is fully committed before the FSM returns to IDLE, so a following read always returns the new data.
- Only one transaction is outstanding at a time; there is no pipelining of requests.
- Reset mid-transaction aborts it. A partially written line keeps the beats already written.
- Bus outputs are 0 whenever they are not defined above.

Decomposition:
- Package sysbus_pkg contains:
  - tag field positions (OP_BIT=12, DEV_MSB=11, DEV_LSB=8)
  - LINE_BEATS=8
  - the state enum resp_state_t {IDLE, RD_LAT, RD_RESP, WR_DATA}
- The package includes Sysbus.defs so the macros remain the single source of op/dev codes.
- Sub-module sysbus_mem_array: MEM_WORDS x 64, one synchronous write port and one combinational read port. The FSM lives in sysbus_mem_responder.

Test Plan:
- Write line at 0x1000, 8 beats of data 0xFFFF_FFFF_FFFF_FFFF down to 0xFFFF_FFFF_FFFF_FFF8, reqcyc held high -> reqack on the header and on every beat; words 0x200..0x207 hold those values; IDLE after the 8th beat.
- Read 0x1000 with tag {READ,MEMORY,0}, respack=1 -> header acked in cycle N; beats in cycles N+4..N+11 = FFFF..FFFF, ..FFFE, ..., ..FFF8; resptag = read tag; respcyc=0 in cycle N+12.
- Read with respack low for 3 cycles at beat 2 -> respcyc stays 1 and bus_resp holds 0xFFFF_FFFF_FFFF_FFFD for 4 cycles; total of 8 beats.
- Read at unaligned address 0x1028 -> identical 8 beats starting with word 0x200; a new header issued during RD_RESP gets reqack=0 until IDLE.
- Reset pulsed for 1 cycle during beat 4 of a read -> next cycle respcyc=0 and state IDLE; a re-issued read of 0x1000 returns the original 8 values.
- Header with dev != `SYSBUS_MEMORY: write is acked for 9 cycles with memory unchanged; read returns 8 beats of 0x0.
